// File: rtl/mem_bus_master_if.sv
// Handshake bundle between the control unit, the bus master and the memory/decoder side.
// The master modport is the bus master's view; slave is the environment's view.
interface mem_bus_master_if;
  logic        REQ;
  logic        REQ_RW;
  logic [15:0] REQ_ADDR;
  logic [15:0] REQ_DATA;
  logic [15:0] MAR_OUT;
  logic [15:0] MDR_OUT;
  logic        MIO_EN;
  logic        RW;
  logic        MEM_EN;
  logic        R;
  logic [15:0] RD_DATA_IN;
  logic [15:0] RD_DATA;
  logic        DONE;
  logic        BUSY;
  logic        TIMEOUT_ERR;

  modport master (
    input  REQ, REQ_RW, REQ_ADDR, REQ_DATA, MEM_EN, R, RD_DATA_IN,
    output MAR_OUT, MDR_OUT, MIO_EN, RW, RD_DATA, DONE, BUSY, TIMEOUT_ERR
  );

  modport slave (
    output REQ, REQ_RW, REQ_ADDR, REQ_DATA, MEM_EN, R, RD_DATA_IN,
    input  MAR_OUT, MDR_OUT, MIO_EN, RW, RD_DATA, DONE, BUSY, TIMEOUT_ERR
  );
endinterface

// File: rtl/mem_bus_master.sv
// Memory bus master: one access per request, to RAM (waits on R with timeout) or to a device register.
// Every output is registered; the RELEASE state waits for R to drop before accepting new work.
module mem_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  mem_bus_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic [15:0] rd_data;
  logic        mio_en;
  logic        rw;
  logic        done;
  logic        busy;
  logic        timeout_err;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      mar         <= 16'd0;
      mdr         <= 16'd0;
      rd_data     <= 16'd0;
      mio_en      <= 1'b0;
      rw          <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.REQ) begin
            mar      <= bus.REQ_ADDR;
            mdr      <= bus.REQ_DATA;
            rw       <= bus.REQ_RW;
            mio_en   <= 1'b1;
            wait_cnt <= 8'd0;
            busy     <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          // Device registers answer immediately; RAM completes on R or gives up at the timeout.
          if (!bus.MEM_EN || bus.R) begin
            if (!rw) begin
              rd_data <= bus.RD_DATA_IN;
            end
            done   <= 1'b1;
            mio_en <= 1'b0;
            state  <= RELEASE;
          end else if (wait_cnt == LAST_WAIT) begin
            done        <= 1'b1;
            timeout_err <= 1'b1;
            mio_en      <= 1'b0;
            state       <= RELEASE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RELEASE: begin
          if (!bus.R) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy   <= 1'b0;
          mio_en <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.MAR_OUT     = mar;
  assign bus.MDR_OUT     = mdr;
  assign bus.MIO_EN      = mio_en;
  assign bus.RW          = rw;
  assign bus.RD_DATA     = rd_data;
  assign bus.DONE        = done;
  assign bus.BUSY        = busy;
  assign bus.TIMEOUT_ERR = timeout_err;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: a small RAM/device model drives the bus side; a negedge monitor
// checks every DONE against a queue of expected responses pushed when each request is issued.
module tb_mem_bus_master;

  logic i_Clk = 1'b0;
  logic i_Reset = 1'b1;

  mem_bus_master_if bus ();

  mem_bus_master #(.TIMEOUT_CYCLES(15)) dut (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .bus     (bus)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic [15:0] rd;
    logic        to;
    int          edge_no;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  int   done_total = 0;
  int   timeout_total = 0;
  int   mio_high_cycles = 0;
  int   mio_starts = 0;
  int   ld_ddr_count = 0;
  logic mio_prev = 1'b0;

  // Memory and device model: RAM raises R one cycle after it sees an enabled access.
  logic [15:0] ram [0:255];
  logic        r_q = 1'b0;
  logic        tie_r_low = 1'b0;
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = 8'd0;
  logic [15:0] pre_data = 16'd0;
  logic        ld_ddr;

  assign bus.MEM_EN     = (bus.MAR_OUT[15:8] != 8'hFF);
  assign bus.R          = r_q && !tie_r_low;
  assign bus.RD_DATA_IN = bus.MEM_EN ? ram[bus.MAR_OUT[7:0]]
                        : ((bus.MAR_OUT == 16'hFF00) ? 16'h0061 : 16'h0000);
  assign ld_ddr = bus.MIO_EN && !bus.MEM_EN && bus.RW && (bus.MAR_OUT == 16'hFF02);

  always @(posedge i_Clk) begin
    edge_cnt <= edge_cnt + 1;
    if (pre_we)
      ram[pre_addr] <= pre_data;
    else if (bus.MIO_EN && bus.MEM_EN && bus.RW)
      ram[bus.MAR_OUT[7:0]] <= bus.MDR_OUT;
    r_q <= bus.MIO_EN && bus.MEM_EN;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: pops one expectation per DONE pulse and tallies bus activity.
  always @(negedge i_Clk) begin
    if (bus.MIO_EN) mio_high_cycles++;
    if (bus.MIO_EN && !mio_prev) mio_starts++;
    mio_prev = bus.MIO_EN;
    if (ld_ddr) ld_ddr_count++;
    if (bus.TIMEOUT_ERR) begin
      timeout_total++;
      checkOutput("timeout_with_done", {31'd0, bus.DONE}, 32'd1);
    end
    if (bus.DONE) begin
      done_total++;
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("rd_data", {16'd0, bus.RD_DATA}, {16'd0, e.rd});
        checkOutput("timeout_err", {31'd0, bus.TIMEOUT_ERR}, {31'd0, e.to});
        checkOutput("done_edge", edge_cnt, e.edge_no);
      end
    end
  end

  task automatic waitIdle(input int budget);
    int n = 0;
    while (bus.BUSY && n < budget) begin
      @(posedge i_Clk);
      #1;
      n++;
    end
    if (bus.BUSY) begin
      tests_run++;
      fails++;
      $display("[TB] FAIL wait_idle: got BUSY=1 after %0d cycles, expected 0", budget);
    end
  endtask

  task automatic preload(input logic [7:0] addr, input logic [15:0] data);
    pre_addr = addr;
    pre_data = data;
    pre_we   = 1'b1;
    @(posedge i_Clk);
    #1;
    pre_we   = 1'b0;
  endtask

  // Issues one request; returns k, the edge that sampled REQ, and optionally queues the expectation.
  task automatic applyStimulus(input logic rw, input logic [15:0] addr, input logic [15:0] data,
                               input bit push, input logic [15:0] exp_rd, input logic exp_to,
                               input int done_ofs, output int k);
    exp_t e;
    waitIdle(60);
    bus.REQ      = 1'b1;
    bus.REQ_RW   = rw;
    bus.REQ_ADDR = addr;
    bus.REQ_DATA = data;
    @(posedge i_Clk);
    #1;
    bus.REQ = 1'b0;
    k = edge_cnt;
    if (push) begin
      e.rd = exp_rd;
      e.to = exp_to;
      e.edge_no = k + done_ofs;
      sb_q.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int snap_a;
    int snap_b;
    bus.REQ      = 1'b0;
    bus.REQ_RW   = 1'b0;
    bus.REQ_ADDR = 16'd0;
    bus.REQ_DATA = 16'd0;
    for (int i = 0; i < 256; i++) ram[i] = 16'd0;

    repeat (2) @(posedge i_Clk);
    #1;
    checkOutput("rst_mar", {16'd0, bus.MAR_OUT}, 32'd0);
    checkOutput("rst_mdr", {16'd0, bus.MDR_OUT}, 32'd0);
    checkOutput("rst_rd_data", {16'd0, bus.RD_DATA}, 32'd0);
    checkOutput("rst_ctrl", {27'd0, bus.MIO_EN, bus.RW, bus.DONE, bus.BUSY, bus.TIMEOUT_ERR}, 32'd0);
    i_Reset = 1'b0;

    preload(8'h03, 16'h1DAA);

    // RAM read with latency checks
    applyStimulus(1'b0, 16'h0003, 16'h0000, 1'b1, 16'h1DAA, 1'b0, 2, k);
    while (edge_cnt < k + 3) begin @(posedge i_Clk); #1; end
    checkOutput("busy_at_k3", {31'd0, bus.BUSY}, 32'd1);
    @(posedge i_Clk);
    #1;
    checkOutput("busy_at_k4", {31'd0, bus.BUSY}, 32'd0);

    // RAM write then read back
    snap_a = done_total;
    applyStimulus(1'b1, 16'h0010, 16'hBEEF, 1'b1, 16'h1DAA, 1'b0, 2, k);
    applyStimulus(1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 2, k);
    waitIdle(20);
    checkOutput("wr_rd_done_count", done_total - snap_a, 32'd2);

    // Device write and device read
    snap_a = mio_high_cycles;
    snap_b = ld_ddr_count;
    applyStimulus(1'b1, 16'hFF02, 16'h0041, 1'b1, 16'hBEEF, 1'b0, 1, k);
    waitIdle(20);
    checkOutput("dev_mio_cycles", mio_high_cycles - snap_a, 32'd1);
    checkOutput("dev_ld_ddr", ld_ddr_count - snap_b, 32'd1);
    applyStimulus(1'b0, 16'hFF00, 16'h0000, 1'b1, 16'h0061, 1'b0, 1, k);
    waitIdle(20);

    // Timeout with R held low
    tie_r_low = 1'b1;
    snap_a = timeout_total;
    applyStimulus(1'b0, 16'h0020, 16'h0000, 1'b1, 16'h0061, 1'b1, 15, k);
    waitIdle(40);
    tie_r_low = 1'b0;
    checkOutput("timeout_pulses", timeout_total - snap_a, 32'd1);
    checkOutput("timeout_idle", {31'd0, bus.BUSY}, 32'd0);

    // Reset one cycle after REQ abandons the access
    snap_a = done_total;
    applyStimulus(1'b0, 16'h0003, 16'h0000, 1'b0, 16'h0000, 1'b0, 0, k);
    i_Reset = 1'b1;
    @(posedge i_Clk);
    #1;
    i_Reset = 1'b0;
    checkOutput("midrst_mar", {16'd0, bus.MAR_OUT}, 32'd0);
    checkOutput("midrst_rd_data", {16'd0, bus.RD_DATA}, 32'd0);
    checkOutput("midrst_ctrl", {27'd0, bus.MIO_EN, bus.RW, bus.DONE, bus.BUSY, bus.TIMEOUT_ERR}, 32'd0);
    applyStimulus(1'b0, 16'h0003, 16'h0000, 1'b1, 16'h1DAA, 1'b0, 2, k);
    waitIdle(20);
    checkOutput("midrst_done_count", done_total - snap_a, 32'd1);

    // REQ held high through a busy read: only one new access after returning to IDLE
    snap_a = mio_starts;
    bus.REQ      = 1'b1;
    bus.REQ_RW   = 1'b0;
    bus.REQ_ADDR = 16'h0003;
    @(posedge i_Clk);
    #1;
    k = edge_cnt;
    sb_q.push_back('{rd: 16'h1DAA, to: 1'b0, edge_no: k + 2});
    waitIdle(20);
    checkOutput("held_req_starts_1", mio_starts - snap_a, 32'd1);
    @(posedge i_Clk);
    #1;
    bus.REQ = 1'b0;
    sb_q.push_back('{rd: 16'h1DAA, to: 1'b0, edge_no: k + 7});
    waitIdle(20);
    repeat (3) @(posedge i_Clk);
    #1;
    checkOutput("held_req_starts_2", mio_starts - snap_a, 32'd2);
    checkOutput("scoreboard_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, is the maximum number of ACCESS cycles spent waiting for R before the access is abandoned (legal range 2..255).
REQ-002 i_Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_Reset  input  1  synchronous, active-high reset.
REQ-004 REQ  input  1  access request from the control unit; sampled only in IDLE.
REQ-005 REQ_RW  input  1  1 = write, 0 = read; sampled with REQ.
REQ-006 REQ_ADDR  input  16  access address; sampled with REQ.
REQ-007 REQ_DATA  input  16  write data; sampled with REQ.
REQ-008 MAR_OUT  output  16  registered address to memory and address decoder.
REQ-009 MDR_OUT  output  16  registered write data to memory.
REQ-010 MIO_EN  output  1  registered enable to the address decoder.
REQ-011 RW  output  1  registered direction to memory and decoder; 1 = write.
REQ-012 MEM_EN  input  1  decoder result; 1 = RAM target, 0 with MIO_EN=1 = device register target.
REQ-013 R  input  1  memory ready flag.
REQ-014 RD_DATA_IN  input  16  read data from the input mux (RAM or device register).
REQ-015 RD_DATA  output  16  captured read data; held until the next successful read.
REQ-016 DONE  output  1  one-cycle completion pulse.
REQ-017 BUSY  output  1  high whenever state is not IDLE.
REQ-018 TIMEOUT_ERR  output  1  high together with DONE when the access timed out; otherwise 0.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS and RELEASE, with an 8-bit wait counter.
REQ-020 In IDLE with REQ=1, the block SHALL load MAR_OUT, MDR_OUT and RW from REQ_ADDR, REQ_DATA and REQ_RW, set MIO_EN=1, clear the counter and enter ACCESS.
- These loads take effect on the same edge that samples REQ.
REQ-021 In ACCESS with MEM_EN=0 (device target), on the next edge the block SHALL:
- capture RD_DATA_IN into RD_DATA if RW=0;
- pulse DONE, clear MIO_EN and enter RELEASE.
REQ-022 In ACCESS with MEM_EN=1 and R=1, on the next edge the block SHALL:
- capture RD_DATA_IN into RD_DATA if RW=0;
- pulse DONE, clear MIO_EN and enter RELEASE.
REQ-023 In ACCESS with MEM_EN=1, R=0 and counter = TIMEOUT_CYCLES-1, on the next edge the block SHALL:
- pulse DONE and TIMEOUT_ERR, leave RD_DATA unchanged, clear MIO_EN and enter RELEASE.
REQ-024 Otherwise in ACCESS, the counter SHALL increment by 1 with no wrap; the timeout check guarantees it never exceeds TIMEOUT_CYCLES-1.
REQ-025 In RELEASE, the block SHALL hold MIO_EN=0 and enter IDLE on the first edge at which R=0, so a stale R never completes the next access.
REQ-026 DONE and TIMEOUT_ERR SHALL each be high for exactly one cycle per access.
REQ-027 REQ asserted outside IDLE SHALL be ignored; it is not queued.
REQ-028 MAR_OUT, MDR_OUT and RW SHALL remain stable from ACCESS entry until IDLE is re-entered.
REQ-029 RAM read latency SHALL be as follows, with REQ sampled at edge k:
- DONE high after edge k+2;
- BUSY low after edge k+4.
REQ-030 Device access latency SHALL be as follows, with REQ sampled at edge k:
- DONE high after edge k+1;
- MIO_EN high for exactly one cycle.

Reset
REQ-031 When i_Reset=1 at an edge, regardless of state, the block SHALL set:
- state IDLE, counter 0;
- MAR_OUT=0, MDR_OUT=0, RD_DATA=0;
- MIO_EN=0, RW=0, DONE=0, BUSY=0, TIMEOUT_ERR=0.
REQ-032 Reset during ACCESS SHALL abandon the access without a DONE pulse; the memory then clears R by itself because MIO_EN=0.
REQ-033 i_Reset SHALL take priority over REQ on the same edge.

Verification
REQ-034 RAM read test: preload ram[0x0003]=0x1DAA, then REQ read 0x0003 -> DONE after edge k+2, RD_DATA=0x1DAA, TIMEOUT_ERR=0, BUSY low after edge k+4.
REQ-035 RAM write then read test: write 0x0010=0xBEEF, then read 0x0010 -> RD_DATA=0xBEEF, with exactly one DONE per access.
REQ-036 Device access tests:
- write 0xFF02 data 0x0041 -> DONE after edge k+1, MIO_EN high for 1 cycle, decoder LD_DDR pulses once;
- read 0xFF00 with RD_DATA_IN=0x0061 -> RD_DATA=0x0061.
REQ-037 Timeout test: tie R=0 with MEM_EN=1 -> DONE and TIMEOUT_ERR high together after 15 ACCESS cycles, RD_DATA unchanged, then IDLE.
REQ-038 Reset mid-access test: assert i_Reset one cycle after REQ -> all outputs 0, no DONE pulse, and a following read of 0x0003 completes normally.
REQ-039 Ignored-request test: hold REQ high through a busy read -> no second access starts until IDLE, then exactly one new access begins.
